// File: rtl/qsram_access_controller_pkg.sv
// Shared definitions for the QSRAM access controller slice.
// Holds the device-matching bus widths, default timing parameters and the
// controller state encoding used by the top-level FSM.
package qsram_pkg;

  localparam int unsigned QSRAM_ADDR_WIDTH       = 33;
  localparam int unsigned QSRAM_DATA_WIDTH       = 9;
  localparam int unsigned QSRAM_READ_LATENCY     = 2;
  localparam int unsigned QSRAM_REFRESH_INTERVAL = 780;
  localparam int unsigned QSRAM_REFRESH_CYCLES   = 4;

  // Wide enough for READ_LATENCY-1 and REFRESH_CYCLES-1 (both <= 14).
  localparam int unsigned QSRAM_CNT_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    WRITE_CMD,
    READ_CMD,
    READ_WAIT,
    REFRESH
  } qsram_state_t;

endpackage

// File: rtl/qsram_access_controller_if.sv
// Host request/response handshake plus the device pin bundle.
//   slave  : controller side (consumes requests, drives device pins)
//   master : host + device side (issues requests, returns MemDataIn)
// Signals: ReqValid/ReqReady/ReqWrite/ReqAddress/ReqWriteData,
//          RspValid/RspReadData, MemAddress/MemEnable/MemRead/MemWrite/
//          MemRefresh/MemDataOut/MemDataOutEnable/MemDataIn.
interface qsram_access_controller_if import qsram_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = QSRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = QSRAM_DATA_WIDTH
) ();

  logic                  ReqValid;
  logic                  ReqReady;
  logic                  ReqWrite;
  logic [ADDR_WIDTH-1:0] ReqAddress;
  logic [DATA_WIDTH-1:0] ReqWriteData;
  logic                  RspValid;
  logic [DATA_WIDTH-1:0] RspReadData;
  logic [ADDR_WIDTH-1:0] MemAddress;
  logic                  MemEnable;
  logic                  MemRead;
  logic                  MemWrite;
  logic                  MemRefresh;
  logic [DATA_WIDTH-1:0] MemDataOut;
  logic                  MemDataOutEnable;
  logic [DATA_WIDTH-1:0] MemDataIn;

  modport slave (
    input  ReqValid, ReqWrite, ReqAddress, ReqWriteData, MemDataIn,
    output ReqReady, RspValid, RspReadData, MemAddress, MemEnable,
           MemRead, MemWrite, MemRefresh, MemDataOut, MemDataOutEnable
  );

  modport master (
    output ReqValid, ReqWrite, ReqAddress, ReqWriteData, MemDataIn,
    input  ReqReady, RspValid, RspReadData, MemAddress, MemEnable,
           MemRead, MemWrite, MemRefresh, MemDataOut, MemDataOutEnable
  );

endinterface

// File: rtl/qsram_access_controller_refresh_timer.sv
// Free-running refresh interval counter with a saturating pending flag.
//   i_clk     : clock
//   i_rst     : synchronous active-high reset
//   i_clear   : FSM is entering a refresh burst this cycle
//   o_pending : a refresh burst is owed
module qsram_refresh_timer import qsram_pkg::*; #(
  parameter int unsigned REFRESH_INTERVAL = QSRAM_REFRESH_INTERVAL
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_pending
);

  localparam int unsigned CW = $clog2(REFRESH_INTERVAL);

  logic [CW-1:0] r_count;
  logic          r_pending;
  logic          w_wrap;

  assign w_wrap    = (r_count == CW'(REFRESH_INTERVAL - 1));
  assign o_pending = r_pending;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_count <= w_wrap ? '0 : r_count + CW'(1);
      // A wrap wins over a simultaneous clear; a second wrap before
      // service just re-sets the same flag.
      if (w_wrap)
        r_pending <= 1'b1;
      else if (i_clear)
        r_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/qsram_access_controller.sv
// Single-beat command sequencer in front of the SDR QSRAM device.
// Accepts host read/write requests, issues device commands, waits out the
// read latency, returns read data and inserts periodic refresh bursts.
//   Clock, Reset : system clock, synchronous active-high reset
//   bus (slave)  : host handshake and device pins
module qsram_access_controller import qsram_pkg::*; #(
  parameter int unsigned ADDR_WIDTH       = QSRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH       = QSRAM_DATA_WIDTH,
  parameter int unsigned READ_LATENCY     = QSRAM_READ_LATENCY,
  parameter int unsigned REFRESH_INTERVAL = QSRAM_REFRESH_INTERVAL,
  parameter int unsigned REFRESH_CYCLES   = QSRAM_REFRESH_CYCLES
) (
  input logic                      Clock,
  input logic                      Reset,
  qsram_access_controller_if.slave bus
);

  localparam int unsigned CW = QSRAM_CNT_WIDTH;
  localparam logic [CW-1:0] READ_RELOAD    = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] REFRESH_RELOAD = CW'(REFRESH_CYCLES - 1);

  qsram_state_t          r_state;
  qsram_state_t          w_next_state;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_next;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_refresh_clear;
  logic                  w_refresh_pending;

  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0] r_mem_data_out;
  logic [DATA_WIDTH-1:0] r_rsp_read_data;
  logic                  r_mem_enable;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic                  r_mem_refresh;
  logic                  r_mem_dout_en;
  logic                  r_rsp_valid;

  qsram_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .i_clk     (Clock),
    .i_rst     (Reset),
    .i_clear   (w_refresh_clear),
    .o_pending (w_refresh_pending)
  );

  // Pending refresh blocks new requests even though the FSM is idle.
  assign bus.ReqReady = (r_state == IDLE) && !w_refresh_pending;

  always_comb begin
    w_next_state    = r_state;
    w_cnt_next      = r_cnt;
    w_accept        = 1'b0;
    w_capture       = 1'b0;
    w_refresh_clear = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_refresh_pending) begin
          w_next_state    = REFRESH;
          w_cnt_next      = REFRESH_RELOAD;
          w_refresh_clear = 1'b1;
        end else if (bus.ReqValid) begin
          w_accept     = 1'b1;
          w_next_state = bus.ReqWrite ? WRITE_CMD : READ_CMD;
        end
      end
      WRITE_CMD: w_next_state = IDLE;
      READ_CMD: begin
        w_next_state = READ_WAIT;
        w_cnt_next   = READ_RELOAD;
      end
      READ_WAIT: begin
        if (r_cnt == '0) begin
          w_capture    = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      REFRESH: begin
        if (r_cnt == '0)
          w_next_state = IDLE;
        else
          w_cnt_next = r_cnt - CW'(1);
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Pin strobes are registered from the next state so they line up exactly
  // with the cycles spent in the corresponding command state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_mem_address   <= '0;
      r_mem_data_out  <= '0;
      r_rsp_read_data <= '0;
      r_mem_enable    <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_refresh   <= 1'b0;
      r_mem_dout_en   <= 1'b0;
      r_rsp_valid     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_mem_address  <= bus.ReqAddress;
        r_mem_data_out <= bus.ReqWriteData;
      end
      r_mem_enable  <= (w_next_state inside {WRITE_CMD, READ_CMD, REFRESH});
      r_mem_read    <= (w_next_state == READ_CMD);
      r_mem_write   <= (w_next_state == WRITE_CMD);
      r_mem_dout_en <= (w_next_state == WRITE_CMD);
      r_mem_refresh <= (w_next_state == REFRESH);
      r_rsp_valid   <= w_capture;
      if (w_capture)
        r_rsp_read_data <= bus.MemDataIn;
    end
  end

  assign bus.MemAddress       = r_mem_address;
  assign bus.MemDataOut       = r_mem_data_out;
  assign bus.MemEnable        = r_mem_enable;
  assign bus.MemRead          = r_mem_read;
  assign bus.MemWrite         = r_mem_write;
  assign bus.MemRefresh       = r_mem_refresh;
  assign bus.MemDataOutEnable = r_mem_dout_en;
  assign bus.RspValid         = r_rsp_valid;
  assign bus.RspReadData      = r_rsp_read_data;

endmodule

// File: doc/qsram_access_controller.md
Name: qsram_access_controller

Overview:
- Synchronous command sequencer directly upstream of the SDR QSRAM device model; owns every pin that device samples.
- Accepts single-beat read/write requests from a host over a valid/ready handshake and drives Address/Enable/Read/Write/Refresh plus the write-data bus.
- Waits out the fixed read latency and returns read data to the host.
- Schedules periodic refresh bursts, which take priority over host traffic.
- Tri-state merging of the data bus happens at the board top using MemDataOutEnable; this block has no inout.

Parameters:
- ADDR_WIDTH, 33, memory address width; must match the device.
- DATA_WIDTH, 9, memory data width; must match the device.
- READ_LATENCY, 2, cycles from the read command cycle to valid MemDataIn; legal range is 1..15.
- REFRESH_INTERVAL, 780, cycles between refresh requests; legal range is >= 16.
- REFRESH_CYCLES, 4, cycles for which Refresh is held asserted; legal range is 1..15.

Ports:
- Clock  input  1  Single system clock; all logic is on the rising edge.
- Reset  input  1  Synchronous, active-high reset.
- ReqValid  input  1  Host request valid.
- ReqReady  output  1  Controller can accept a request this cycle.
- ReqWrite  input  1  1 means write, 0 means read.
- ReqAddress  input  ADDR_WIDTH  Request address.
- ReqWriteData  input  DATA_WIDTH  Write payload.
- RspValid  output  1  One-cycle pulse; RspReadData is valid in that cycle.
- RspReadData  output  DATA_WIDTH  Captured read data.
- MemAddress  output  ADDR_WIDTH  To device Address.
- MemEnable  output  1  To device Enable.
- MemRead  output  1  To device Read.
- MemWrite  output  1  To device Write.
- MemRefresh  output  1  To device Refresh.
- MemDataOut  output  DATA_WIDTH  Write data driven toward the device.
- MemDataOutEnable  output  1  High only in a write command cycle; the top-level tri-state uses it.
- MemDataIn  input  DATA_WIDTH  Data returned from the device bus.

Behaviour:
- Clock and reset: one clock and a synchronous active-high reset, as already decided. Ports are named Clock and Reset.
- Output registering: all Mem*, RspValid and RspReadData outputs are registered. ReqReady is combinational from state and refresh-pending.
- Reset values: every output is 0, including MemAddress, MemDataOut and RspReadData. State is IDLE, the refresh counter is 0 and RefreshPending is 0.
- Reset mid-operation: the in-flight command is abandoned and no RspValid is produced.
- State machine states: IDLE, WRITE_CMD, READ_CMD, READ_WAIT, REFRESH.
- IDLE:
  - ReqReady = !RefreshPending.
  - If RefreshPending, go to REFRESH.
  - Otherwise, if ReqValid is high, latch address/data/kind and go to WRITE_CMD or READ_CMD.
  - Refresh wins over a simultaneous ReqValid; the request stays pending on the host side.
- WRITE_CMD (exactly 1 cycle):
  - MemEnable=1, MemWrite=1, MemDataOutEnable=1.
  - MemAddress and MemDataOut hold the latched values.
  - Next state is IDLE.
- READ_CMD (exactly 1 cycle):
  - MemEnable=1, MemRead=1, MemAddress holds the latched value.
  - Next state is READ_WAIT, with the wait counter loaded to READ_LATENCY-1.
- READ_WAIT:
  - MemEnable=0; MemAddress holds its value.
  - Decrement the counter. When it is 0, capture MemDataIn into RspReadData, assert RspValid for the following cycle, and go to IDLE.
- Read timing check: if a request is accepted at edge T, the command cycle is T+1 and RspValid is high in cycle T+2+READ_LATENCY.
- Write throughput: one write every 2 cycles.
- REFRESH:
  - MemEnable=1 and MemRefresh=1 for REFRESH_CYCLES consecutive cycles.
  - MemRead, MemWrite and MemDataOutEnable stay 0.
  - Then go to IDLE.
- Refresh counter:
  - Free-running from 0 to REFRESH_INTERVAL-1, then wraps; it runs in all states.
  - On wrap it sets RefreshPending.
  - Entering REFRESH clears RefreshPending.
  - If a wrap coincides with entry to REFRESH, RefreshPending ends at 1.
  - Pending saturates: a second wrap before service does not queue two bursts.
- Mutual exclusion invariant: at most one of MemRead/MemWrite/MemRefresh is high in any cycle. MemDataOutEnable=1 implies MemWrite=1.
- Host contract: the host must hold ReqAddress, ReqWriteData and ReqWrite stable only while ReqValid && !ReqReady.

Decomposition:
- Shared package qsram_pkg holds:
  - the state enum, qsram_state_t;
  - address/data width constants, so they match the device;
  - defaults for READ_LATENCY, REFRESH_CYCLES and REFRESH_INTERVAL.
- One sub-module: qsram_refresh_timer, containing the interval counter and the saturating pending flag, with a clear input from the FSM.
- The FSM and datapath stay in the top module.

Test Plan:
- Reset then idle: hold Reset for 3 cycles, then release. All outputs are 0 and ReqReady=1 the first cycle after release. RefreshPending is first set 780 cycles later and MemRefresh is high for exactly 4 cycles.
- Single write: addr 0x1_2345_6789, data 0x1A5 (9-bit). One cycle with MemEnable=MemWrite=MemDataOutEnable=1 and the matching MemAddress/MemDataOut. ReqReady is low for that cycle only.
- Single read with READ_LATENCY=2: drive MemDataIn=0x0F3 in the capture cycle. RspValid is high in cycle T+4 and RspReadData=0x0F3; no spurious RspValid appears.
- Refresh collision: assert ReqValid (read) in the same cycle RefreshPending sets. The refresh burst comes first and ReqReady stays 0 for 4 cycles. The read is then accepted and completes normally.
- Back-to-back traffic: 100 random mixed requests with ReqValid held high, checked against a scoreboard memory. The mutual-exclusion invariant holds every cycle and every read matches the last write.
- Reset mid-read: assert Reset during READ_WAIT. No RspValid is produced, all outputs are 0 the next cycle, and a new read afterwards works.
